// File: rtl/start_screen_ctrl.sv
// Start-screen overlay sequencer: coin credits, blinking text, launch countdown
// and hand-over to the game core. All timing is counted in startOfFrame pulses.
module start_screen_ctrl #(
  parameter int unsigned BLINK_FRAMES  = 30,
  parameter int unsigned LAUNCH_FRAMES = 60,
  parameter int unsigned MAX_CREDITS   = 9
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       coinKey,
  input  logic       startKey,
  input  logic       gameOver,
  output logic       standBy,
  output logic       startScreenEn,
  output logic       gameStart,
  output logic [3:0] credits
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CRED_W = 4;

  localparam logic [1:0] ST_ATTRACT = 2'd0;
  localparam logic [1:0] ST_READY   = 2'd1;
  localparam logic [1:0] ST_LAUNCH  = 2'd2;
  localparam logic [1:0] ST_PLAYING = 2'd3;

  localparam logic [CNT_W-1:0]  BLINK_LAST  = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0]  LAUNCH_LAST = CNT_W'(LAUNCH_FRAMES - 1);
  localparam logic [CRED_W-1:0] CRED_MAX    = CRED_W'(MAX_CREDITS);

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  frame_cnt, cnt_nxt;
  logic [CRED_W-1:0] credits_nxt;
  logic              standby_nxt, en_nxt, gs_nxt;
  logic              coin_d, start_d;
  logic              coin_e, start_e, accept;

  assign coin_e  = coinKey & ~coin_d;
  assign start_e = startKey & ~start_d;
  assign accept  = start_e && (state == ST_READY);

  // Credit bookkeeping; a coin and an accepted start cancel out.
  always_comb begin
    credits_nxt = credits;
    if (coin_e && !accept) begin
      if (credits < CRED_MAX)
        credits_nxt = credits + CRED_W'(1);
    end else if (accept && !coin_e) begin
      credits_nxt = credits - CRED_W'(1);
    end
  end

  // Next state, blink phase, frame counter and overlay controls.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = frame_cnt;
    standby_nxt = standBy;
    en_nxt      = startScreenEn;
    gs_nxt      = 1'b0;
    case (state)
      ST_ATTRACT, ST_READY: begin
        en_nxt = 1'b1;
        if (startOfFrame) begin
          if (frame_cnt == BLINK_LAST) begin
            standby_nxt = ~standBy;
            cnt_nxt     = '0;
          end else begin
            cnt_nxt = frame_cnt + CNT_W'(1);
          end
        end
        if (state == ST_ATTRACT) begin
          if (credits_nxt != '0)
            state_nxt = ST_READY;
        end else if (accept) begin
          state_nxt   = ST_LAUNCH;
          standby_nxt = 1'b1;
        end
      end
      ST_LAUNCH: begin
        standby_nxt = 1'b1;
        en_nxt      = 1'b1;
        if (startOfFrame) begin
          if (frame_cnt == LAUNCH_LAST) begin
            state_nxt = ST_PLAYING;
            gs_nxt    = 1'b1;
            en_nxt    = 1'b0;
          end else begin
            cnt_nxt = frame_cnt + CNT_W'(1);
          end
        end
      end
      ST_PLAYING: begin
        standby_nxt = 1'b1;
        en_nxt      = 1'b0;
        if (startOfFrame)
          cnt_nxt = frame_cnt + CNT_W'(1);
        if (gameOver) begin
          state_nxt = (credits_nxt != '0) ? ST_READY : ST_ATTRACT;
          en_nxt    = 1'b1;
        end
      end
      default: begin
        state_nxt   = ST_ATTRACT;
        standby_nxt = 1'b1;
        en_nxt      = 1'b1;
      end
    endcase
    // A state change always restarts frame counting from zero.
    if (state_nxt != state)
      cnt_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state         <= ST_ATTRACT;
      frame_cnt     <= '0;
      credits       <= '0;
      standBy       <= 1'b1;
      startScreenEn <= 1'b1;
      gameStart     <= 1'b0;
      coin_d        <= 1'b0;
      start_d       <= 1'b0;
    end else begin
      state         <= state_nxt;
      frame_cnt     <= cnt_nxt;
      credits       <= credits_nxt;
      standBy       <= standby_nxt;
      startScreenEn <= en_nxt;
      gameStart     <= gs_nxt;
      coin_d        <= coinKey;
      start_d       <= startKey;
    end
  end

endmodule
